// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_pkg
//  Purpose  : Default 640x480@60 raster constants, derived totals and
//             sync-window bounds, plus helpers for per-axis derivation.
//  Revision : 1.0  initial release
// ============================================================================
package vga_timing_pkg;

    // Counter and coordinate widths
    localparam int CNT_W   = 10;
    localparam int POS_W   = 9;
    localparam int FRAME_W = 8;

    // Default horizontal timing (pixels)
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;

    // Default vertical timing (lines)
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    // Total period of one axis
    function automatic int axis_total(input int vis, input int fr, input int sy, input int bk);
        return vis + fr + sy + bk;
    endfunction

    // First count value at which sync is active
    function automatic int sync_first(input int vis, input int fr);
        return vis + fr;
    endfunction

    // Last count value at which sync is active
    function automatic int sync_last(input int vis, input int fr, input int sy);
        return vis + fr + sy - 1;
    endfunction

    localparam int H_TOTAL = axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int V_TOTAL = axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

    localparam int H_SYNC_FIRST = sync_first(DEF_H_VISIBLE, DEF_H_FRONT);
    localparam int H_SYNC_LAST  = sync_last(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC);
    localparam int V_SYNC_FIRST = sync_first(DEF_V_VISIBLE, DEF_V_FRONT);
    localparam int V_SYNC_LAST  = sync_last(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC);

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
//  Module   : vga_axis_counter
//  Purpose  : One raster axis (horizontal or vertical). Holds the position
//             counter and reports the post-update count, the wrap event and
//             the sync/visible decode of that post-update count.
//  Revision : 1.0  initial release
// ============================================================================
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE = DEF_H_VISIBLE,
    parameter int FRONT   = DEF_H_FRONT,
    parameter int SYNC    = DEF_H_SYNC,
    parameter int BACK    = DEF_H_BACK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             wrap_o,
    output logic             sync_o,
    output logic             visible_o
);

    localparam logic [CNT_W-1:0] c_LAST       = CNT_W'(axis_total(VISIBLE, FRONT, SYNC, BACK) - 1);
    localparam logic [CNT_W-1:0] c_SYNC_FIRST = CNT_W'(sync_first(VISIBLE, FRONT));
    localparam logic [CNT_W-1:0] c_SYNC_LAST  = CNT_W'(sync_last(VISIBLE, FRONT, SYNC));
    localparam logic [CNT_W-1:0] c_VISIBLE    = CNT_W'(VISIBLE);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == c_LAST);

    // Next count: advance on step, fold back to zero after the last position
    always_comb begin
        cnt_d = cnt_q;
        if (step_i) begin
            cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Position register; async reset restarts the axis at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Decodes are taken from the next count so the caller can register them
    // in the same edge as the counter itself and stay aligned with it.
    assign cnt_o     = cnt_d;
    assign wrap_o    = step_i & at_last;
    assign sync_o    = (cnt_d >= c_SYNC_FIRST) && (cnt_d <= c_SYNC_LAST);
    assign visible_o = (cnt_d < c_VISIBLE);

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Raster timing generator for the game renderer. Produces H/V
//             sync, half-resolution pixel coordinates, display enable and
//             single-clock line/frame strobes. All outputs are registered
//             from the post-update counters.
//  Config   : define VGA_FRAME_CNT_EN to add the 8-bit frame_cnt output.
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int CLK_DIV   = 1,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               h_sync,
    output logic               v_sync,
    output logic [POS_W-1:0]   h_pos,
    output logic [POS_W-1:0]   v_pos,
    output logic               vga_enable,
    output logic               line_start,
`ifdef VGA_FRAME_CNT_EN
    output logic [FRAME_W-1:0] frame_cnt,
`endif
    output logic               frame_start
);

    localparam logic [1:0] c_DIV_LAST  = 2'(CLK_DIV - 1);
    localparam logic       c_SYNC_IDLE = ~SYNC_POL;

    // ------------------------------------------------------------------
    // Pixel-enable divider
    // ------------------------------------------------------------------
    logic [1:0] div_q;
    logic [1:0] div_d;
    logic       pix_en;

    assign pix_en = (div_q == 2'd0);
    assign div_d  = (div_q == c_DIV_LAST) ? 2'd0 : div_q + 2'd1;

    // Free-running clk divider; zero after reset so the first clk is a pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= 2'd0;
        end else begin
            div_q <= div_d;
        end
    end

    // ------------------------------------------------------------------
    // Axis counters: V advances once per completed line
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             h_sync_act;
    logic             v_sync_act;
    logic             h_vis;
    logic             v_vis;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_axis (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_i    (pix_en),
        .cnt_o     (h_cnt),
        .wrap_o    (h_wrap),
        .sync_o    (h_sync_act),
        .visible_o (h_vis)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v_axis (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_i    (h_wrap),
        .cnt_o     (v_cnt),
        .wrap_o    (v_wrap),
        .sync_o    (v_sync_act),
        .visible_o (v_vis)
    );

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic             h_sync_q;
    logic             v_sync_q;
    logic [POS_W-1:0] h_pos_q;
    logic [POS_W-1:0] v_pos_q;
    logic             vga_enable_q;
    logic             line_start_q;
    logic             frame_start_q;

    // Register all raster outputs together; strobes come from the wrap events,
    // which only exist on a pixel-enable clk, so they last a single clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_sync_q      <= c_SYNC_IDLE;
            v_sync_q      <= c_SYNC_IDLE;
            h_pos_q       <= '0;
            v_pos_q       <= '0;
            vga_enable_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_sync_q      <= h_sync_act ? SYNC_POL : c_SYNC_IDLE;
            v_sync_q      <= v_sync_act ? SYNC_POL : c_SYNC_IDLE;
            h_pos_q       <= POS_W'(h_cnt >> 1);
            v_pos_q       <= POS_W'(v_cnt >> 1);
            vga_enable_q  <= h_vis & v_vis;
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
        end
    end

    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign h_pos       = h_pos_q;
    assign v_pos       = v_pos_q;
    assign vga_enable  = vga_enable_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
    logic [FRAME_W-1:0] frame_cnt_q;

    // Frames since reset, naturally wrapping at the register width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (v_wrap) begin
            frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule
`default_nettype wire
